// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - parametrised RV32I hazard controller: forwarding, bypass, load-use, flush, multi-cycle hold
// Optional perf counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_wb,
  input  logic              d_is_load,
  input  logic              d_is_mc,
  input  logic              e_br_taken,
  output logic              stall,
  output logic              flush,
  output logic              e_hold,
  output logic              mc_busy,
  output logic [SEL_W-1:0]  e_fwd_sel1,
  output logic [SEL_W-1:0]  e_fwd_sel2,
  output logic              d_byp1,
  output logic              d_byp2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MC_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wb;
    logic              load;
    logic              mc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
  } slot_t;

  slot_t           e_q;
  slot_t           d_tag;
  slot_t           st_q [1:FWD_STAGES];
  logic [MC_W-1:0] mc_cnt;
  logic            load_use;
  logic            e_take;

  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wb && (s.rd == r) && (r != '0);
  endfunction

  assign mc_busy  = (mc_cnt != '0);
  assign e_hold   = mc_busy;
  // Gate with rst_n so flush is low while reset is asserted.
  assign flush    = rst_n && e_br_taken && !mc_busy;
  assign load_use = e_q.load && ((d_use_rs1 && writes(e_q, d_rs1)) ||
                                 (d_use_rs2 && writes(e_q, d_rs2)));
  assign stall    = mc_busy || (load_use && !flush);
  assign e_take   = d_valid && !stall && !flush;

  assign d_byp1 = d_use_rs1 && writes(st_q[FWD_STAGES], d_rs1);
  assign d_byp2 = d_use_rs2 && writes(st_q[FWD_STAGES], d_rs2);

  always_comb begin
    d_tag = '0;
    if (e_take) begin
      d_tag.valid = 1'b1;
      d_tag.rd    = d_rd;
      d_tag.wb    = d_wb;
      d_tag.load  = d_is_load;
      d_tag.mc    = d_is_mc;
      d_tag.rs1   = d_rs1;
      d_tag.rs2   = d_rs2;
      d_tag.use1  = d_use_rs1;
      d_tag.use2  = d_use_rs2;
    end
  end

  // Scan farthest to nearest so the youngest producer wins.
  always_comb begin
    e_fwd_sel1 = '0;
    e_fwd_sel2 = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (e_q.use1 && writes(st_q[k], e_q.rs1)) e_fwd_sel1 = SEL_W'(k);
      if (e_q.use2 && writes(st_q[k], e_q.rs2)) e_fwd_sel2 = SEL_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      mc_cnt <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) st_q[k] <= '0;
    end else begin
      if (mc_busy) begin
        mc_cnt  <= mc_cnt - MC_W'(1);
        st_q[1] <= '0;
      end else begin
        e_q     <= d_tag;
        st_q[1] <= e_q;
        if (e_take && d_is_mc) mc_cnt <= MC_W'(MC_LAT - 1);
      end
      for (int k = 2; k <= FWD_STAGES; k++) st_q[k] <= st_q[k-1];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the RV32I core, successor to the fixed 5-stage controller. Tracks in-flight destination tags from Execute through FWD_STAGES downstream stages (M..W) and generates Execute forwarding selects and Decode write-back bypasses. Also generates load-use stalls, branch/jump flushes and multi-cycle-unit holds, for cores with a deeper back end or a multi-cycle ALU (MUL/DIV).

Parameters:
REG_AW, 5, register index width
FWD_STAGES, 2, stages after E carrying results (stage 1 = M, stage FWD_STAGES = W); legal range 1..6
MC_LAT, 4, multi-cycle unit latency in cycles, >= 1
CNT_W, 16, performance counter width
SEL_W, $clog2(FWD_STAGES+1), forwarding select width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset
d_valid  in  1  Decode holds a real instruction
d_rs1, d_rs2  in  REG_AW  Decode source indices
d_use_rs1, d_use_rs2  in  1  source actually read
d_rd  in  REG_AW  Decode destination
d_wb  in  1  Decode instruction writes rd
d_is_load  in  1  Decode instruction is a load
d_is_mc  in  1  Decode instruction uses the multi-cycle unit
e_br_taken  in  1  E-stage branch taken or jal/jalr; redirect
stall  out  1  hold PC and F/D register
flush  out  1  squash F/D and D/E (bubble)
e_hold  out  1  hold D/E register; datapath keeps E operands
mc_busy  out  1  multi-cycle unit occupied
e_fwd_sel1, e_fwd_sel2  out  SEL_W  0 = D/E register value, k = result of stage k
d_byp1, d_byp2  out  1  Decode takes W write-back data instead of register file
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset asynchronous, active-low: all tag slots invalid, mc counter 0, counters 0. All outputs 0 during reset.
- Tag slot = {valid, rd, wb, load, mc, rs1, rs2, use1, use2}. E slot plus FWD_STAGES shift stages.
- Each clock, without hold: E slot <= Decode tag (valid = d_valid & ~stall & ~flush); stage1 <= E; stage k <= stage k-1.
- "Writes r" for a slot = valid & wb & rd == r & r != 0.
- Load-use: stall = E writes d_rs1 with d_use_rs1, or E writes d_rs2 with d_use_rs2, while E is a load. Duration one cycle; bubble inserted into E.
- Multi-cycle: an mc op entering E loads the counter with MC_LAT-1. While counter != 0: mc_busy = e_hold = stall = 1, E slot frozen, bubble shifted into stage 1, counter decrements. At 0 the op advances normally. MC_LAT = 1 never holds.
- Flush: e_br_taken & ~mc_busy -> flush = 1 same cycle; E slot <= bubble; stall suppressed. e_br_taken is ignored while mc_busy.
- Priority: mc hold > flush > load-use stall.
- Forwarding, per operand, combinational from E slot: select smallest k whose stage k writes E.rs and E.use; else 0. Loads are forwardable from stage 1 onward.
- Decode bypass: d_bypN = d_useN & stage FWD_STAGES writes d_rsN. The register file has no write-before-read.
- Index 0 never forwards, bypasses or stalls.
- Reset mid-hold clears the counter and all slots immediately.

Optional Feature:
HAZ_PERF_CNT_EN defined: stall_cnt increments each cycle stall = 1; flush_cnt increments each cycle flush = 1. Both saturate at all-ones. Not defined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- lw x5 in E, add x6,x5,x1 in D -> stall = 1 for exactly 1 cycle. Next cycle e_fwd_sel1 = 1 (stage M), stall = 0.
- add x3 in stage 1 and add x3 in stage 2, consumer in E reads x3 -> e_fwd_sel = 1 (nearest stage wins); with rd = x0 instead -> e_fwd_sel = 0.
- MC_LAT = 4, mul enters E -> mc_busy/e_hold/stall high for 3 cycles, stage 1 receives 3 bubbles, mul reaches stage 1 on the 4th edge. e_br_taken pulsed during the hold -> flush stays 0.
- e_br_taken with D instruction valid -> flush = 1, next cycle E slot invalid. In the same cycle a load-use condition is present -> stall = 0.
- W writes x7 while D reads x7 as rs2 of a store -> d_byp2 = 1; with d_use_rs2 = 0 -> d_byp2 = 0.
- rst_n asserted mid mc hold -> all outputs 0 immediately. After release, no stale forwarding; with HAZ_PERF_CNT_EN, stall_cnt = 0.
